lpm_bipad_ctrl: RTL

Sequencer and arbiter for one lpm_bipad instance. Shares the bidirectional pad bus between a write requester and a read requester. Drives the bipad `enable` and `data` inputs and samples its `result` output. Inserts programmable turnaround gaps so the pad is never driven from both sides at once.

---
 rtl/lpm_bipad_ctrl_if.sv | 29 ++
 rtl/lpm_bipad_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/lpm_bipad_ctrl_if.sv
// Bundle of requester-side and pad-side signals for lpm_bipad_ctrl.
// The slave modport is the controller's view; master is the requester/pad side.
interface lpm_bipad_ctrl_if #(
   parameter int lpm_width = 8
);
   logic                 wr_req;
   logic [lpm_width-1:0] wr_data;
   logic                 wr_ack;
   logic                 rd_req;
   logic [lpm_width-1:0] rd_data;
   logic                 rd_valid;
   logic                 enable;
   logic [lpm_width-1:0] data;
   logic [lpm_width-1:0] result;
   logic                 busy;
   logic [1:0]           state_dbg;

   // Handshake: a requester raises *_req and holds it until its wr_ack or
   // rd_valid pulse; requests are only looked at while the controller is idle.
   modport slave (
      input  wr_req, wr_data, rd_req, result,
      output wr_ack, rd_data, rd_valid, enable, data, busy, state_dbg
   );

   modport master (
      output wr_req, wr_data, rd_req, result,
      input  wr_ack, rd_data, rd_valid, enable, data, busy, state_dbg
   );
endinterface

// File: rtl/lpm_bipad_ctrl.sv
// Write/read sequencer for one lpm_bipad: round-robin arbitration between the
// write and read requesters, with a read wait window and a turnaround gap.
module lpm_bipad_ctrl #(
   parameter int    lpm_width      = 8,
   parameter int    lpm_turnaround = 1,
   parameter int    lpm_rd_wait    = 0,
   parameter string lpm_type       = "lpm_bipad_ctrl"
) (
   input logic              clock,
   input logic              aclr,
   lpm_bipad_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, TURN} state_e;

   localparam logic [3:0] RD_WAIT   = 4'(lpm_rd_wait);
   localparam logic [3:0] TURN_LOAD = (lpm_turnaround > 0) ? 4'(lpm_turnaround - 1) : 4'd0;
   localparam bit         NO_TURN   = (lpm_turnaround == 0);

   state_e               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 last_wr_q, last_wr_d;
   logic                 enable_q, enable_d;
   logic [lpm_width-1:0] data_q, data_d;
   logic                 wr_ack_q, wr_ack_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [lpm_width-1:0] rd_data_q, rd_data_d;
   logic                 busy_q, busy_d;
   logic                 grant_wr, grant_rd;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_wr_d  = last_wr_q;
      data_d     = data_q;
      rd_data_d  = rd_data_q;
      enable_d   = 1'b0;
      wr_ack_d   = 1'b0;
      rd_valid_d = 1'b0;
      // On a tie the write wins unless the previous grant was a write.
      grant_wr   = bus.wr_req && (!bus.rd_req || !last_wr_q);
      grant_rd   = bus.rd_req && !grant_wr;

      case (state_q)
         IDLE: begin
            if (grant_wr) begin
               state_d   = DRIVE;
               data_d    = bus.wr_data;
               enable_d  = 1'b1;
               wr_ack_d  = 1'b1;
               last_wr_d = 1'b1;
            end else if (grant_rd) begin
               state_d   = SAMPLE;
               cnt_d     = RD_WAIT;
               last_wr_d = 1'b0;
            end
         end
         DRIVE: begin
            state_d = NO_TURN ? IDLE : TURN;
            cnt_d   = TURN_LOAD;
         end
         SAMPLE: begin
            if (cnt_q == 4'd0) begin
               rd_data_d  = bus.result;
               rd_valid_d = 1'b1;
               state_d    = NO_TURN ? IDLE : TURN;
               cnt_d      = TURN_LOAD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         TURN: begin
            if (cnt_q == 4'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         last_wr_q  <= 1'b0;
         enable_q   <= 1'b0;
         data_q     <= '0;
         wr_ack_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_wr_q  <= last_wr_d;
         enable_q   <= enable_d;
         data_q     <= data_d;
         wr_ack_q   <= wr_ack_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.enable    = enable_q;
   assign bus.data      = data_q;
   assign bus.wr_ack    = wr_ack_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.busy      = busy_q;
   assign bus.state_dbg = state_q;

endmodule
